// File: rtl/vdg_pkg.sv
// Shared VDG video-path definitions: mode encodings and common widths.
package vdg_pkg;

    // Display modes carried alongside each byte
    localparam logic [1:0] MODE_SG = 2'd0;
    localparam logic [1:0] MODE_RG = 2'd1;
    localparam logic [1:0] MODE_CG = 2'd2;

    // Default colour index width for the palette/DAC stage
    localparam int unsigned COLOUR_W_DEF = 4;

    // Bits consumed per CG pixel; also the palette index width
    localparam int unsigned CG_SLICE_W = 2;

endpackage

// File: rtl/pixel_colour_map.sv
// Combinational mapper from shifter state (mode + top pixel bits) to a colour index.
module pixel_colour_map
    import vdg_pkg::*;
#(
    parameter int unsigned COLOUR_W = COLOUR_W_DEF
) (
    input  logic                  active,
    input  logic [1:0]            mode,
    input  logic [1:0]            bits,
    input  logic [COLOUR_W-1:0]   scol,
    input  logic [COLOUR_W-1:0]   fg,
    input  logic [COLOUR_W-1:0]   bg,
    input  logic [4*COLOUR_W-1:0] palette,
    output logic [COLOUR_W-1:0]   colour
);

    // Idle and the reserved mode both give colour 0
    always_comb begin
        colour = '0;
        if (active) begin
            case (mode)
                MODE_SG: colour = bits[1] ? scol : '0;
                MODE_RG: colour = bits[1] ? fg : bg;
                MODE_CG: colour = palette[int'(bits)*COLOUR_W +: COLOUR_W];
                default: colour = '0;
            endcase
        end
    end

endmodule

// File: rtl/pixel_shift_engine.sv
// Double-buffered pixel serialiser: holding register feeds an MSB-first shifter
// producing 1 bpp (SG/RG) or 2 bpp (CG) colour indices with programmable stretch.
module pixel_shift_engine
    import vdg_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COLOUR_W  = COLOUR_W_DEF,
    parameter int unsigned STRETCH_W = 2
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  PixelEn,
    input  logic                  Flush,
    input  logic [DATA_W-1:0]     Data,
    input  logic [COLOUR_W-1:0]   SColour,
    input  logic                  DataValid,
    output logic                  DataReady,
    input  logic [1:0]            Mode,
    input  logic [STRETCH_W-1:0]  Stretch,
    input  logic [COLOUR_W-1:0]   FgColour,
    input  logic [COLOUR_W-1:0]   BgColour,
    input  logic [4*COLOUR_W-1:0] Palette,
    output logic [COLOUR_W-1:0]   Colour,
    output logic                  Underrun
);

    localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] PIX_LAST_1BPP = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PIX_LAST_CG   = CNT_W'(DATA_W / 2 - 1);

    // Holding stage
    logic                 hold_full;
    logic [DATA_W-1:0]    hold_data;
    logic [COLOUR_W-1:0]  hold_scol;
    logic [1:0]           hold_mode;

    // Shift stage
    logic                 active;
    logic [DATA_W-1:0]    shift_data;
    logic [COLOUR_W-1:0]  shift_scol;
    logic [1:0]           shift_mode;
    logic [STRETCH_W-1:0] shift_stretch;
    logic [CNT_W-1:0]     pix_cnt;
    logic [STRETCH_W-1:0] str_cnt;
    logic                 underrun;

    logic last_tick;
    logic capture;
    logic transfer;
    logic advance;

    assign DataReady = ~hold_full;
    assign Underrun  = underrun;

    // Handshake decode; Flush overrides both capture and transfer
    always_comb begin
        last_tick = active && (pix_cnt == '0) && (str_cnt == '0);
        capture   = DataValid && !hold_full && !Flush;
        transfer  = PixelEn && hold_full && (!active || last_tick) && !Flush;
        advance   = PixelEn && active && !Flush;
    end

    // Holding register: fills on capture, empties on transfer or flush
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_scol <= '0;
            hold_mode <= '0;
        end else if (Flush) begin
            hold_full <= 1'b0;
        end else if (capture) begin
            hold_full <= 1'b1;
            hold_data <= Data;
            hold_scol <= SColour;
            hold_mode <= Mode;
        end else if (transfer) begin
            hold_full <= 1'b0;
        end
    end

    // Shift register, pixel/stretch counters and the underrun pulse
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            active        <= 1'b0;
            shift_data    <= '0;
            shift_scol    <= '0;
            shift_mode    <= '0;
            shift_stretch <= '0;
            pix_cnt       <= '0;
            str_cnt       <= '0;
            underrun      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (Flush) begin
                active  <= 1'b0;
                pix_cnt <= '0;
                str_cnt <= '0;
            end else if (transfer) begin
                active        <= 1'b1;
                shift_data    <= hold_data;
                shift_scol    <= hold_scol;
                shift_mode    <= hold_mode;
                shift_stretch <= Stretch;
                pix_cnt       <= (hold_mode == MODE_CG) ? PIX_LAST_CG : PIX_LAST_1BPP;
                str_cnt       <= Stretch;
            end else if (advance) begin
                if (str_cnt != '0) begin
                    str_cnt <= str_cnt - 1'b1;
                end else if (pix_cnt == '0) begin
                    // Last pixel done and nothing waiting: go idle
                    active   <= 1'b0;
                    underrun <= 1'b1;
                end else begin
                    shift_data <= (shift_mode == MODE_CG) ? (shift_data << CG_SLICE_W)
                                                          : (shift_data << 1);
                    pix_cnt    <= pix_cnt - 1'b1;
                    str_cnt    <= shift_stretch;
                end
            end
        end
    end

    pixel_colour_map #(
        .COLOUR_W (COLOUR_W)
    ) u_colour_map (
        .active  (active),
        .mode    (shift_mode),
        .bits    (shift_data[DATA_W-1 -: 2]),
        .scol    (shift_scol),
        .fg      (FgColour),
        .bg      (BgColour),
        .palette (Palette),
        .colour  (Colour)
    );

endmodule

// File: tb/tb_pixel_shift_engine.sv
// Directed self-checking bench for pixel_shift_engine (DATA_W=8, COLOUR_W=4).
module tb_pixel_shift_engine;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        PixelEn = 1'b0;
    logic        Flush = 1'b0;
    logic [7:0]  Data = '0;
    logic [3:0]  SColour = '0;
    logic        DataValid = 1'b0;
    logic        DataReady;
    logic [1:0]  Mode = '0;
    logic [1:0]  Stretch = '0;
    logic [3:0]  FgColour = '0;
    logic [3:0]  BgColour = '0;
    logic [15:0] Palette = '0;
    logic [3:0]  Colour;
    logic        Underrun;

    int tests = 0;
    int fails = 0;

    pixel_shift_engine #(
        .DATA_W    (8),
        .COLOUR_W  (4),
        .STRETCH_W (2)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .PixelEn   (PixelEn),
        .Flush     (Flush),
        .Data      (Data),
        .SColour   (SColour),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .Mode      (Mode),
        .Stretch   (Stretch),
        .FgColour  (FgColour),
        .BgColour  (BgColour),
        .Palette   (Palette),
        .Colour    (Colour),
        .Underrun  (Underrun)
    );

    always #5 Clk = ~Clk;

    // Offer one byte for a single edge; DataReady must already be high
    task automatic send(input logic [7:0] d, input logic [3:0] sc, input logic [1:0] m,
                        input logic [1:0] st);
        Data = d; SColour = sc; Mode = m; Stretch = st; DataValid = 1'b1;
        @(negedge Clk);
        DataValid = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0; PixelEn = 1'b1;
        @(negedge Clk); @(negedge Clk);
        tests++; if (DataReady !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", DataReady); end
        tests++; if (Colour !== 4'h0) begin fails++; $display("FAIL reset_colour got %h exp 0", Colour); end
        tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", Underrun); end
        nReset = 1'b1;
        @(negedge Clk);
        tests++; if (DataReady !== 1'b1 || Colour !== 4'h0) begin
            fails++; $display("FAIL reset_release got rdy=%b col=%h exp rdy=1 col=0", DataReady, Colour);
        end
    endtask

    task automatic test_sg();
        logic [7:0] b;
        logic [3:0] exp;
        b = 8'hA5;
        send(b, 4'h3, 2'd0, 2'd0);
        tests++; if (DataReady !== 1'b0) begin fails++; $display("FAIL sg_ready_low got %b exp 0", DataReady); end
        @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            exp = b[7-i] ? 4'h3 : 4'h0;
            tests++; if (Colour !== exp) begin fails++; $display("FAIL sg_pix%0d got %h exp %h", i, Colour, exp); end
            tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL sg_no_underrun%0d got %b exp 0", i, Underrun); end
            @(negedge Clk);
        end
        tests++; if (Underrun !== 1'b1 || Colour !== 4'h0) begin
            fails++; $display("FAIL sg_end got und=%b col=%h exp und=1 col=0", Underrun, Colour);
        end
        @(negedge Clk);
        tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL sg_underrun_once got %b exp 0", Underrun); end
    endtask

    task automatic test_rg_stretch();
        logic [3:0] exp;
        FgColour = 4'hF; BgColour = 4'h1;
        send(8'hF0, 4'h0, 2'd1, 2'd1);
        @(negedge Clk);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 8) ? 4'hF : 4'h1;
            tests++; if (Colour !== exp) begin fails++; $display("FAIL rg_cyc%0d got %h exp %h", i, Colour, exp); end
            @(negedge Clk);
        end
        tests++; if (Underrun !== 1'b1 || Colour !== 4'h0) begin
            fails++; $display("FAIL rg_end got und=%b col=%h exp und=1 col=0", Underrun, Colour);
        end
        @(negedge Clk);
    endtask

    task automatic test_cg_mode_change();
        logic [15:0] expv;
        logic [3:0]  exp;
        Palette = {4'hD, 4'hC, 4'hB, 4'hA};
        expv = 16'hABCD;
        send(8'b00_01_10_11, 4'h0, 2'd2, 2'd0);
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            exp = expv[15-4*i -: 4];
            tests++; if (Colour !== exp) begin fails++; $display("FAIL cg_pix%0d got %h exp %h", i, Colour, exp); end
            if (i == 1) begin Mode = 2'd0; Stretch = 2'd3; end
            @(negedge Clk);
        end
        tests++; if (Underrun !== 1'b1 || Colour !== 4'h0) begin
            fails++; $display("FAIL cg_end got und=%b col=%h exp und=1 col=0", Underrun, Colour);
        end
        @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1;
        logic [7:0] b2;
        logic [3:0] exp;
        logic       exp_rdy;
        b1 = 8'hC3; b2 = 8'h81;
        send(b1, 4'h5, 2'd0, 2'd0);
        @(negedge Clk);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 8) ? (b1[7-i] ? 4'h5 : 4'h0) : (b2[15-i] ? 4'h7 : 4'h0);
            exp_rdy = !(i >= 1 && i <= 7);
            tests++; if (Colour !== exp) begin fails++; $display("FAIL b2b_pix%0d got %h exp %h", i, Colour, exp); end
            tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL b2b_gap%0d got und=%b exp 0", i, Underrun); end
            tests++; if (DataReady !== exp_rdy) begin fails++; $display("FAIL b2b_rdy%0d got %b exp %b", i, DataReady, exp_rdy); end
            if (i == 0) begin Data = b2; SColour = 4'h7; DataValid = 1'b1; end
            if (i == 1) DataValid = 1'b0;
            @(negedge Clk);
        end
        tests++; if (Underrun !== 1'b1 || Colour !== 4'h0) begin
            fails++; $display("FAIL b2b_end got und=%b col=%h exp und=1 col=0", Underrun, Colour);
        end
        @(negedge Clk);
    endtask

    task automatic test_flush();
        send(8'hFF, 4'h9, 2'd0, 2'd0);
        @(negedge Clk); @(negedge Clk); @(negedge Clk);
        tests++; if (Colour !== 4'h9) begin fails++; $display("FAIL flush_pre got %h exp 9", Colour); end
        Flush = 1'b1; Data = 8'h55; DataValid = 1'b1;
        @(negedge Clk);
        Flush = 1'b0; DataValid = 1'b0;
        tests++; if (Colour !== 4'h0) begin fails++; $display("FAIL flush_colour got %h exp 0", Colour); end
        tests++; if (DataReady !== 1'b1) begin fails++; $display("FAIL flush_ready got %b exp 1", DataReady); end
        tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL flush_underrun got %b exp 0", Underrun); end
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            tests++; if (Colour !== 4'h0 || Underrun !== 1'b0) begin
                fails++; $display("FAIL flush_idle%0d got col=%h und=%b exp col=0 und=0", i, Colour, Underrun);
            end
        end
    endtask

    task automatic test_pixel_en_reset();
        logic [7:0] b;
        logic [3:0] exp;
        b = 8'hA0;
        PixelEn = 1'b0;
        send(b, 4'h6, 2'd0, 2'd0);
        tests++; if (DataReady !== 1'b0) begin fails++; $display("FAIL pe_capture got %b exp 0", DataReady); end
        PixelEn = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 7; i++) begin
            exp = b[7-i/3] ? 4'h6 : 4'h0;
            tests++; if (Colour !== exp) begin fails++; $display("FAIL pe_cyc%0d got %h exp %h", i, Colour, exp); end
            PixelEn = ((i + 1) % 3 == 0);
            if (i == 1) begin Data = 8'hFF; SColour = 4'hE; DataValid = 1'b1; end
            if (i == 2) DataValid = 1'b0;
            if (i >= 2) begin
                tests++; if (DataReady !== 1'b0) begin fails++; $display("FAIL pe_held%0d got %b exp 0", i, DataReady); end
            end
            if (i < 6) @(negedge Clk);
        end
        nReset = 1'b0;
        #1;
        tests++; if (Colour !== 4'h0) begin fails++; $display("FAIL rst_mid_colour got %h exp 0", Colour); end
        tests++; if (DataReady !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b exp 1", DataReady); end
        tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL rst_mid_underrun got %b exp 0", Underrun); end
        @(negedge Clk);
        nReset = 1'b1; PixelEn = 1'b1;
        @(negedge Clk);
        send(8'h80, 4'h2, 2'd0, 2'd0);
        tests++; if (Colour !== 4'h0) begin fails++; $display("FAIL rst_restart_wait got %h exp 0", Colour); end
        @(negedge Clk);
        tests++; if (Colour !== 4'h2) begin fails++; $display("FAIL rst_restart_first got %h exp 2", Colour); end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_sg();
        test_rg_stretch();
        test_cg_mode_change();
        test_back_to_back();
        test_flush();
        test_pixel_en_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish within 200000");
        $fatal(1);
    end

endmodule

// File: doc/pixel_shift_engine.md
# pixel_shift_engine

- Parametrised, double-buffered pixel serialiser for the VDG video path.
- Accepts one display byte per handshake and serialises it MSB-first, at 1 or 2 bits per pixel, into a COLOUR_W colour index.
- Modes: semigraphics (SG), two-colour resolution graphics (RG) and four-colour colour graphics (CG), with programmable pixel stretch.
- Sits between the display-fetch logic and the palette/DAC stage; supersedes the fixed 8-bit semigraphics shifter.

## Interface
Parameters:
- DATA_W, 8, display byte width; must be even.
- COLOUR_W, 4, colour index width.
- STRETCH_W, 2, width of the pixel-stretch field.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- PixelEn  in  1  pixel-clock enable; shifting and counting advance only when high.
- Flush  in  1  synchronous line-end clear.
- Data  in  DATA_W  display byte.
- SColour  in  COLOUR_W  SG foreground colour; captured with Data.
- DataValid  in  1  Data/SColour valid.
- DataReady  out  1  holding register empty; capture occurs when DataValid && DataReady.
- Mode  in  2  0=SG, 1=RG, 2=CG, 3=reserved; captured with Data.
- Stretch  in  STRETCH_W  Clk-enables per pixel minus 1; sampled at transfer.
- FgColour, BgColour  in  COLOUR_W  RG colours; live, not latched.
- Palette  in  4*COLOUR_W  CG colours; entry k at bits [k*COLOUR_W +: COLOUR_W]; live.
- Colour  out  COLOUR_W  current pixel colour.
- Underrun  out  1  one-cycle pulse when the shifter runs dry.

## Operation
Two stages: holding register (Data, SColour, Mode, full flag) and shift register (byte, latched SColour/Mode/Stretch, pixel counter, stretch counter, active flag).

Capture:
- On DataValid && DataReady: holding loads on the edge and becomes full.
- DataReady = !hold_full, registered; no same-cycle refill.

Transfer:
- Occurs on a PixelEn cycle when the holding register is full and either the shifter is idle or the last stretch tick of the last pixel is completing.
- Effects:
  - Holding empties.
  - Shift loads the byte.
  - Pixel counter loads DATA_W-1 (1bpp) or DATA_W/2-1 (CG).
  - Stretch counter loads Stretch.
  - Active is set.

Advance, on each PixelEn cycle while active:
- If the stretch counter is nonzero, decrement it.
- Otherwise, shift left 1 bit (SG/RG) or 2 bits (CG), decrement the pixel counter and reload the stretch counter.

Colour, combinational from registered state:
- Idle: 0.
- SG: MSB ? latched SColour : 0.
- RG: MSB ? FgColour : BgColour.
- CG: Palette entry indexed by the top two bits.
- Mode 3: 0.

Underrun:
- Last pixel completes with holding empty: active clears and Underrun pulses high for that one cycle.
- No further pulses while idle.

Flush:
- Clears hold_full, active and the counters; no Underrun.
- Flush wins over a simultaneous capture (byte discarded) and over a transfer.

Mode or Stretch changes never affect a byte already in the shifter.

## Timing
- Reset values: DataReady=1, Colour=0, Underrun=0, holding and shift registers zero, idle.
- Capture edge to DataReady low: same edge.
- With the shifter idle and PixelEn high, a byte accepted at edge N transfers at edge N+1. Its first pixel appears on Colour after edge N+1.
- Pixel duration: (Stretch+1) PixelEn cycles.
- Byte duration: (pixels per byte)*(Stretch+1) PixelEn cycles.
- Back-to-back bytes produce no gap pixel, provided the holding register is refilled before the final pixel ends.
- PixelEn low freezes shift, counters and Colour; capture still operates.
- nReset asserted mid-byte: immediate return to reset values; first byte after release follows the idle-start timing.

## Structure
- Shared package vdg_pkg holds:
  - mode constants MODE_SG=2'd0, MODE_RG=2'd1, MODE_CG=2'd2;
  - the default COLOUR_W;
  - the CG palette-slice width.
- One natural sub-module: pixel_colour_map, the combinational mode/bits-to-colour mapper. The top level keeps the handshake, counters and shift register.
- Expected size: 150-250 lines of RTL.

## Test plan
- Reset, then SG byte 8'hA5 with SColour 4'h3, Stretch 0, PixelEn constant → Colour sequence 3,0,3,0,0,3,0,3; Underrun pulses once after the 8th pixel.
- RG byte 8'hF0 with Fg 4'hF, Bg 4'h1, Stretch 1 → each colour held 2 cycles: F×8 cycles, then 1×8 cycles.
- CG byte 8'b00_01_10_11 with Palette {4'hD,4'hC,4'hB,4'hA} (entry 3 first) → A,B,C,D. Mode changed to SG mid-byte → no change in output.
- Second byte offered the cycle DataReady rises during byte one → seamless 16-pixel stream; no Underrun between bytes; DataReady low while held.
- Flush asserted with DataValid mid-byte → Colour 0 next cycle, DataReady 1, byte discarded, no Underrun.
- PixelEn 1-in-3 duty with SG 8'h80 → pixel held 3 Clk; nReset pulled mid-byte → Colour 0, DataReady 1 immediately.
